// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Imported by the field counter and the timer top.
package countdown_pkg;

    localparam int CD_W       = 6;
    localparam int CD_MAX_VAL = 59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } cd_state_t;

    // Saturate an out-of-range preset to the field maximum.
    function automatic logic [CD_W-1:0] cd_clamp(
        input logic [CD_W-1:0] v,
        input logic [CD_W-1:0] mx
    );
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/mod_down_counter.sv
// One MM or SS field: loadable modulo-(MAX_VAL+1) down-counter.
// borrow flags the cycle in which an enabled count wraps from 0.
module mod_down_counter
    import countdown_pkg::*;
#(
    parameter int MAX_VAL = CD_MAX_VAL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            load,
    input  logic [CD_W-1:0] d,
    output logic [CD_W-1:0] q,
    output logic            zero,
    output logic            borrow
);

    localparam logic [CD_W-1:0] MAXV = CD_W'(MAX_VAL);

    // Field register: reset, then load (clamped), then decrement with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= cd_clamp(d, MAXV);
        end else if (en) begin
            q <= (q == '0) ? MAXV : q - CD_W'(1);
        end
    end

    assign zero   = (q == '0);
    assign borrow = en & zero;

endmodule

// File: rtl/countdown_timer.sv
// Loadable MM:SS countdown timer with start/pause/resume and expiry.
// Seconds borrow drives the minutes field; the FSM lives here.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int MAX_VAL = CD_MAX_VAL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            load,
    input  logic [CD_W-1:0] load_min,
    input  logic [CD_W-1:0] load_sec,
    input  logic            start,
    input  logic            pause,
    output logic [CD_W-1:0] min,
    output logic [CD_W-1:0] sec,
    output logic            running,
    output logic            expired,
    output logic            done
);

    cd_state_t state_q, state_d;
    logic      done_q, done_d;
    logic      sec_en, sec_zero, sec_borrow;
    logic      min_zero, min_borrow;
    logic      cnt_zero, last_tick;

    // Count only in RUN; load has priority over tick.
    assign sec_en    = (state_q == RUN) & tick & ~load;
    assign cnt_zero  = sec_zero & min_zero;
    assign last_tick = sec_en & min_zero & (sec == CD_W'(1));

    mod_down_counter #(.MAX_VAL(MAX_VAL)) u_sec (
        .clk    (clk),
        .reset  (reset),
        .en     (sec_en),
        .load   (load),
        .d      (load_sec),
        .q      (sec),
        .zero   (sec_zero),
        .borrow (sec_borrow)
    );

    mod_down_counter #(.MAX_VAL(MAX_VAL)) u_min (
        .clk    (clk),
        .reset  (reset),
        .en     (sec_borrow),
        .load   (load),
        .d      (load_min),
        .q      (min),
        .zero   (min_zero),
        .borrow (min_borrow)
    );

    // State and done-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state: load first, then per-state start/pause/tick handling.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, PAUSED: begin
                    if (start) begin
                        if (cnt_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_tick) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (pause) begin
                        state_d = PAUSED;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);
    assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: directed table of multi-cycle rows, then random
// stimulus against a total-seconds reference model.
module tb_countdown_timer;

    localparam int MX   = 59;
    localparam int BASE = MX + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, load = 1'b0;
    logic       start = 1'b0, pause = 1'b0;
    logic [5:0] load_min = '0, load_sec = '0;
    logic [5:0] min, sec;
    logic       running, expired, done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    countdown_timer #(.MAX_VAL(MX)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .pause    (pause),
        .min      (min),
        .sec      (sec),
        .running  (running),
        .expired  (expired),
        .done     (done)
    );

    typedef struct {
        logic       r, t, l;
        logic [5:0] lm, ls;
        logic       s, p;
        int         n;
        logic [5:0] em, es;
        logic       er, ex, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(
        logic r, logic t, logic l, int lm, int ls, logic s, logic p,
        int n, int em, int es, logic er, logic ex, logic ed
    );
        vec_t x;
        x.r = r; x.t = t; x.l = l;
        x.lm = 6'(lm); x.ls = 6'(ls);
        x.s = s; x.p = p; x.n = n;
        x.em = 6'(em); x.es = 6'(es);
        x.er = er; x.ex = ex; x.ed = ed;
        return x;
    endfunction

    task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(
        logic r, logic t, logic l, logic [5:0] lm, logic [5:0] ls,
        logic s, logic p
    );
        reset = r; tick = t; load = l;
        load_min = lm; load_sec = ls;
        start = s; pause = p;
        @(posedge clk);
        #1;
    endtask

    // Reference model: remaining time as plain seconds plus a mode.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_cnt = 0;
    int m_mode = M_IDLE;
    int m_done = 0;

    function automatic int clampf(int x);
        return (x > MX) ? MX : x;
    endfunction

    task automatic model_step(
        logic r, logic t, logic l, int lm, int ls, logic s, logic p
    );
        m_done = 0;
        if (r) begin
            m_cnt = 0;
            m_mode = M_IDLE;
        end else if (l) begin
            m_cnt = clampf(lm) * BASE + clampf(ls);
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE, M_PAUSE: begin
                    if (s) begin
                        if (m_cnt == 0) begin
                            m_mode = M_DONE;
                            m_done = 1;
                        end else begin
                            m_mode = M_RUN;
                        end
                    end
                end
                M_RUN: begin
                    if (t) m_cnt = m_cnt - 1;
                    if (t && m_cnt == 0) begin
                        m_mode = M_DONE;
                        m_done = 1;
                    end else if (p) begin
                        m_mode = M_PAUSE;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        // r t l lm ls s p n | min sec run exp done
        tbl.push_back(v(1,0,0, 0, 0,0,0, 1,  0, 0,0,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 5,  0, 0,0,0,0));
        tbl.push_back(v(0,0,1, 1, 2,0,0, 1,  1, 2,0,0,0));
        tbl.push_back(v(0,1,0, 0, 0,1,0, 1,  1, 2,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 1,  1, 1,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 1,  1, 0,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 1,  0,59,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0,58,  0, 1,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 1,  0, 0,0,1,1));
        tbl.push_back(v(0,1,0, 0, 0,1,0, 1,  0, 0,0,1,0));
        tbl.push_back(v(0,0,0, 0, 0,0,1, 1,  0, 0,0,1,0));
        tbl.push_back(v(0,0,1, 0,10,0,0, 1,  0,10,0,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,0, 1,  0,10,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 3,  0, 7,1,0,0));
        tbl.push_back(v(0,0,0, 0, 0,0,1, 1,  0, 7,0,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 4,  0, 7,0,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,0, 1,  0, 7,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 2,  0, 5,1,0,0));
        tbl.push_back(v(0,0,1,63,60,0,0, 1, 59,59,0,0,0));
        tbl.push_back(v(0,0,1, 5,61,0,0, 1,  5,59,0,0,0));
        tbl.push_back(v(0,1,1, 0, 5,1,0, 1,  0, 5,0,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,0, 1,  0, 5,1,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,1, 1,  0, 5,0,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,1, 1,  0, 5,1,0,0));
        tbl.push_back(v(0,0,1, 0, 0,0,0, 1,  0, 0,0,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,0, 1,  0, 0,0,1,1));
        tbl.push_back(v(0,1,0, 0, 0,1,0, 3,  0, 0,0,1,0));
        tbl.push_back(v(0,0,1, 2, 0,0,0, 1,  2, 0,0,0,0));
        tbl.push_back(v(0,0,0, 0, 0,1,0, 1,  2, 0,1,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0,10,  1,50,1,0,0));
        tbl.push_back(v(1,1,1, 3, 3,1,0, 1,  0, 0,0,0,0));
        tbl.push_back(v(0,1,0, 0, 0,0,0, 1,  0, 0,0,0,0));

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                drive(tbl[i].r, tbl[i].t, tbl[i].l, tbl[i].lm,
                      tbl[i].ls, tbl[i].s, tbl[i].p);
                if (k < tbl[i].n - 1)
                    chk($sformatf("row%0d.done_mid", i), 8'(done), 8'd0);
            end
            chk($sformatf("row%0d.min", i), 8'(min), 8'(tbl[i].em));
            chk($sformatf("row%0d.sec", i), 8'(sec), 8'(tbl[i].es));
            chk($sformatf("row%0d.running", i), 8'(running), 8'(tbl[i].er));
            chk($sformatf("row%0d.expired", i), 8'(expired), 8'(tbl[i].ex));
            chk($sformatf("row%0d.done", i), 8'(done), 8'(tbl[i].ed));
        end

        // Random phase, model synchronised through a reset.
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            logic r, t, l, s, p;
            logic [5:0] lm, ls;
            r  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 39) == 0);
            t  = ($urandom_range(0, 1) == 1);
            s  = ($urandom_range(0, 9) == 0);
            p  = ($urandom_range(0, 14) == 0);
            lm = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                             : 6'($urandom_range(0, 1));
            ls = 6'($urandom_range(0, 63));
            drive(r, t, l, lm, ls, s, p);
            model_step(r, t, l, int'(lm), int'(ls), s, p);
            chk($sformatf("rnd%0d.min", c), 8'(min), 8'(m_cnt / BASE));
            chk($sformatf("rnd%0d.sec", c), 8'(sec), 8'(m_cnt % BASE));
            chk($sformatf("rnd%0d.running", c), 8'(running),
                8'(m_mode == M_RUN));
            chk($sformatf("rnd%0d.expired", c), 8'(expired),
                8'(m_mode == M_DONE));
            chk($sformatf("rnd%0d.done", c), 8'(done), 8'(m_done));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
